// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversampling ratio and baud divider math.
// With UART_RX_PARITY_EN defined the state type widens to 3 bits to hold PARITY.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    STOP   = 3'b011,
    PARITY = 3'b100
  } uart_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;
`endif

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_tick_div(input int clk_freq, input int baud_rate);
    return (clk_freq + (baud_rate * OVERSAMPLE) / 2) / (baud_rate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/baud_rate_gen.sv
// Free-running oversample tick generator: o_tick is high for one clk every TICK_DIV clocks.
// Shared between the UART receiver and transmitter.
module baud_rate_gen #(
  parameter int TICK_DIV = 163
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Divider counter with registered tick output.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      cnt_r  <= cnt_r + CW'(1);
      tick_r <= 1'b0;
    end
  end

  assign o_tick = tick_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and a two-flop input synchronizer.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 19200,
  parameter int TICK_DIV  = calc_tick_div(CLK_FREQ, BAUD_RATE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_rx,
  output logic            o_rx_done,
  output logic [DBIT-1:0] o_data,
  output logic            o_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            o_parity_err
`endif
);

  localparam int SCW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int NCW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SCW-1:0] S_MID   = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] S_LAST  = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] SB_LAST = SCW'(SB_TICK - 1);
  localparam logic [NCW-1:0] N_LAST  = NCW'(DBIT - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_state_t AFTER_DATA = PARITY;

  // High when data plus parity bit hold an odd number of ones.
  function automatic logic even_parity_fail(input logic [DBIT-1:0] d, input logic p);
    return ^{d, p};
  endfunction
`else
  localparam uart_state_t AFTER_DATA = STOP;
`endif

  logic            rx_meta_r, rx_sync_r, rx_s, s_tick;
  uart_state_t     state_r, state_nxt;
  logic [SCW-1:0]  s_cnt_r, s_cnt_nxt;
  logic [NCW-1:0]  n_cnt_r, n_cnt_nxt;
  logic [DBIT-1:0] b_r, b_nxt, data_r, data_nxt;
  logic            rx_done_r, rx_done_nxt, frame_err_r, frame_err_nxt, stop_hit_s;
`ifdef UART_RX_PARITY_EN
  logic            par_r, par_nxt, parity_err_r, parity_err_nxt;
`endif

  baud_rate_gen #(.TICK_DIV(TICK_DIV)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .o_tick (s_tick)
  );

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= i_rx;
      rx_sync_r <= rx_meta_r;
    end
  end
  assign rx_s = rx_sync_r;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      s_cnt_r     <= '0;
      n_cnt_r     <= '0;
      b_r         <= '0;
      data_r      <= '0;
      rx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_r        <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt;
      s_cnt_r     <= s_cnt_nxt;
      n_cnt_r     <= n_cnt_nxt;
      b_r         <= b_nxt;
      data_r      <= data_nxt;
      rx_done_r   <= rx_done_nxt;
      frame_err_r <= frame_err_nxt;
`ifdef UART_RX_PARITY_EN
      par_r        <= par_nxt;
      parity_err_r <= parity_err_nxt;
`endif
    end
  end

  // Next-state and counter logic; counters only move on oversample ticks.
  always_comb begin
    state_nxt = state_r;
    s_cnt_nxt = s_cnt_r;
    n_cnt_nxt = n_cnt_r;
    b_nxt     = b_r;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_r;
`endif
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          s_cnt_nxt = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (s_tick && (s_cnt_r == S_MID)) begin
          if (!rx_s) begin
            state_nxt = DATA;
            s_cnt_nxt = '0;
            n_cnt_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (s_tick) begin
          s_cnt_nxt = s_cnt_r + SCW'(1);
        end else begin
          state_nxt = START;
        end
      end
      DATA: begin
        if (s_tick && (s_cnt_r == S_LAST)) begin
          s_cnt_nxt = '0;
          b_nxt     = {rx_s, b_r[DBIT-1:1]};
          if (n_cnt_r == N_LAST) begin
            state_nxt = AFTER_DATA;
          end else begin
            n_cnt_nxt = n_cnt_r + NCW'(1);
          end
        end else if (s_tick) begin
          s_cnt_nxt = s_cnt_r + SCW'(1);
        end else begin
          state_nxt = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick && (s_cnt_r == S_LAST)) begin
          s_cnt_nxt = '0;
          par_nxt   = rx_s;
          state_nxt = STOP;
        end else if (s_tick) begin
          s_cnt_nxt = s_cnt_r + SCW'(1);
        end else begin
          state_nxt = PARITY;
        end
      end
`endif
      STOP: begin
        if (s_tick && (s_cnt_r == SB_LAST)) begin
          state_nxt = IDLE;
        end else if (s_tick) begin
          s_cnt_nxt = s_cnt_r + SCW'(1);
        end else begin
          state_nxt = STOP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode at the final stop-bit sample.
  always_comb begin
    stop_hit_s    = (state_r == STOP) && s_tick && (s_cnt_r == SB_LAST);
    rx_done_nxt   = 1'b0;
    frame_err_nxt = 1'b0;
    data_nxt      = data_r;
`ifdef UART_RX_PARITY_EN
    parity_err_nxt = 1'b0;
`endif
    if (stop_hit_s && rx_s) begin
      rx_done_nxt = 1'b1;
      data_nxt    = b_r;
`ifdef UART_RX_PARITY_EN
      parity_err_nxt = even_parity_fail(b_r, par_r);
`endif
    end else if (stop_hit_s) begin
      frame_err_nxt = 1'b1;
    end else begin
      rx_done_nxt = 1'b0;
    end
  end

  assign o_rx_done   = rx_done_r;
  assign o_frame_err = frame_err_r;
  assign o_data      = data_r;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frames, a negedge monitor checks pulses.
module tb_uart_rx;

  localparam int TD   = 4;
  localparam int BIT  = 16 * TD;
  localparam int DBIT = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NB = DBIT + 1;
`else
  localparam int NB = DBIT;
`endif
  // Pulse expected one register stage after the mid-stop-bit sample.
  localparam int LAT_MIN = (NB + 1) * BIT + BIT / 2 - TD;
  localparam int LAT_MAX = (NB + 1) * BIT + BIT / 2 + 2 * TD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       o_rx_done, o_frame_err;
  logic [7:0] o_data;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  uart_rx #(.DBIT(DBIT), .SB_TICK(16), .TICK_DIV(TD)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (rx),
    .o_rx_done   (o_rx_done),
    .o_data      (o_data),
    .o_frame_err (o_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(o_parity_err)
`endif
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         ferr;
    bit         perr;
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_val, input int stop_len,
                            input bit par_flip);
    exp_t e;
    e.start = cyc;
    e.ferr  = !stop_val;
    e.perr  = stop_val ? par_flip : 1'b0;
    e.data  = stop_val ? d : last_good;
    if (stop_val) last_good = d;
    sb_q.push_back(e);
    drive(1'b0, BIT);
    for (int i = 0; i < DBIT; i++) drive(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive((^d) ^ par_flip, BIT);
`endif
    drive(stop_val, stop_len);
    rx = 1'b1;
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   lat;
    if (!rst && (o_rx_done || o_frame_err)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b frame_err=%0b data=%0h, none expected",
                 o_rx_done, o_frame_err, o_data);
      end else begin
        e   = sb_q.pop_front();
        lat = cyc - e.start;
        check("rx_done", 32'(o_rx_done), 32'(!e.ferr));
        check("frame_err", 32'(o_frame_err), 32'(e.ferr));
        check("data", 32'(o_data), 32'(e.data));
`ifdef UART_RX_PARITY_EN
        check("parity_err", 32'(o_parity_err), 32'(e.perr));
`endif
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
          errors++;
          $display("FAIL latency: got %0d clk expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
        end
      end
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    check("reset_done", 32'(o_rx_done), 32'h0);
    check("reset_ferr", 32'(o_frame_err), 32'h0);
    check("reset_data", 32'(o_data), 32'h0);
    rst = 1'b0;
    drive(1'b1, 2000);
    check("idle_data", 32'(o_data), 32'h0);

    send_frame(8'h03, 1'b1, BIT, 1'b0);
    drive(1'b1, 2 * BIT);

    // Back-to-back: second start bit follows the first stop bit directly.
    send_frame(8'hA5, 1'b1, BIT, 1'b0);
    fork
      send_frame(8'h3C, 1'b1, BIT, 1'b0);
      begin
        repeat (5 * BIT) @(negedge clk);
        check("hold_a5", 32'(o_data), 32'hA5);
      end
    join
    drive(1'b1, 2 * BIT);

    // Three-tick glitch must be rejected, then a normal frame follows.
    drive(1'b0, 3 * TD);
    drive(1'b1, 3 * BIT);
    check("glitch_data", 32'(o_data), 32'h3C);
    send_frame(8'h01, 1'b1, BIT, 1'b0);
    drive(1'b1, 2 * BIT);

    // Stop bit low past its mid sample, then line released.
    send_frame(8'hFF, 1'b0, 44, 1'b0);
    drive(1'b1, 3 * BIT);
    check("ferr_hold", 32'(o_data), 32'h01);

    // Reset during bit 4 of 0x55; frame is abandoned.
    drive(1'b0, BIT);
    drive(1'b1, BIT);
    drive(1'b0, BIT);
    drive(1'b1, BIT);
    drive(1'b0, BIT);
    drive(1'b1, BIT / 2);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    drive(1'b1, 3 * BIT);
    check("data_after_rst", 32'(o_data), 32'h0);
    send_frame(8'h80, 1'b1, BIT, 1'b0);
    drive(1'b1, 2 * BIT);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, BIT, 1'b1);
    drive(1'b1, 2 * BIT);
`endif

    for (int i = 0; i < 4000 && sb_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected pulses never seen, required 0", sb_q.size());
    end
    drive(1'b1, 2 * BIT);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
